// File: rtl/d_reg_defs.sv
`default_nettype none
// ============================================================================
//  Module      : d_reg_defs (package)
//  Description : Shared definitions for the universal data register: the
//                mode field width and the eight operation codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package d_reg_defs;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROTL = 3'd4,
        MODE_ROTR = 3'd5,
        MODE_SET  = 3'd6,
        MODE_CLR  = 3'd7
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/d_reg_next_mux.sv
`default_nettype none
// ============================================================================
//  Module      : d_reg_next_mux
//  Description : Combinational next-state function of the universal register.
//                Ports:
//                  q_i          current stored word
//                  mode_i       operation code
//                  en_i         update enable (0 = hold)
//                  d_i          parallel load data
//                  si_i         serial input bit
//                  q_next_o     word to store on the next edge
//                  so_next_o    bit expelled by a shift/rotate
//                  so_update_o  1 when so_next_o should be captured
//  Revision    : 1.0 - initial release
// ============================================================================
module d_reg_next_mux
    import d_reg_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  q_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              en_i,
    input  logic [WIDTH-1:0]  d_i,
    input  logic              si_i,
    output logic [WIDTH-1:0]  q_next_o,
    output logic              so_next_o,
    output logic              so_update_o
);

    // Shift/rotate results depend on WIDTH; a 1-bit word has no interior
    // slice, so it gets its own degenerate form.
    logic [WIDTH-1:0] shl_d, shr_d, rotl_d, rotr_d;

    generate
        if (WIDTH == 1) begin : g_narrow
            assign shl_d  = si_i;
            assign shr_d  = si_i;
            assign rotl_d = q_i;
            assign rotr_d = q_i;
        end else begin : g_wide
            assign shl_d  = {q_i[WIDTH-2:0], si_i};
            assign shr_d  = {si_i, q_i[WIDTH-1:1]};
            assign rotl_d = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            assign rotr_d = {q_i[0], q_i[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        q_next_o    = q_i;
        so_next_o   = 1'b0;
        so_update_o = 1'b0;
        if (en_i) begin
            case (mode_e'(mode_i))
                MODE_HOLD: q_next_o = q_i;
                MODE_LOAD: q_next_o = d_i;
                MODE_SHL: begin
                    q_next_o    = shl_d;
                    so_next_o   = q_i[WIDTH-1];
                    so_update_o = 1'b1;
                end
                MODE_SHR: begin
                    q_next_o    = shr_d;
                    so_next_o   = q_i[0];
                    so_update_o = 1'b1;
                end
                MODE_ROTL: begin
                    q_next_o    = rotl_d;
                    so_next_o   = q_i[WIDTH-1];
                    so_update_o = 1'b1;
                end
                MODE_ROTR: begin
                    q_next_o    = rotr_d;
                    so_next_o   = q_i[0];
                    so_update_o = 1'b1;
                end
                MODE_SET:  q_next_o = {WIDTH{1'b1}};
                MODE_CLR:  q_next_o = {WIDTH{1'b0}};
                default:   q_next_o = q_i;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/d_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module      : d_reg_universal
//  Description : Clocked universal data register (hold/load/shift/rotate/
//                set/clear) with shift-out bit and change pulse.
//                Ports:
//                  clk_in       clock, rising edge
//                  reset_in     synchronous active-high reset
//                  en_in        update enable
//                  mode_in      operation code
//                  d_in         parallel load data
//                  si_in        serial input bit
//                  q_out        stored word
//                  so_out       bit expelled by the most recent shift
//                  changed_out  q_out changed on the previous edge
//  Revision    : 1.0 - initial release
// ============================================================================
module d_reg_universal
    import d_reg_defs::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              en_in,
    input  logic [MODE_W-1:0] mode_in,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              si_in,
    output logic [WIDTH-1:0]  q_out,
    output logic              so_out,
    output logic              changed_out
);

    logic [WIDTH-1:0] q_q;
    logic             so_q;
    logic             changed_q;

    logic [WIDTH-1:0] q_d;
    logic             so_d;
    logic             so_upd;

    d_reg_next_mux #(
        .WIDTH (WIDTH)
    ) u_next (
        .q_i         (q_q),
        .mode_i      (mode_in),
        .en_i        (en_in),
        .d_i         (d_in),
        .si_i        (si_in),
        .q_next_o    (q_d),
        .so_next_o   (so_d),
        .so_update_o (so_upd)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            q_q       <= RESET_VALUE;
            so_q      <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            // The change pulse is evaluated every edge; a disabled edge
            // yields q_d == q_q and therefore clears it.
            changed_q <= (q_d != q_q);
            if (so_upd) begin
                so_q <= so_d;
            end
        end
    end

    assign q_out       = q_q;
    assign so_out      = so_q;
    assign changed_out = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_d_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_reg_universal
//  Description : Self-checking bench for d_reg_universal (WIDTH=8 and WIDTH=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_reg_universal;
    import d_reg_defs::*;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       si;
        logic [7:0] q;
        logic       so;
        logic       ch;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       rst8, en8, si8;
    logic [2:0] mode8;
    logic [7:0] d8, q8;
    logic       so8, ch8;

    // WIDTH=1 instance
    logic       rst1, en1, si1;
    logic [2:0] mode1;
    logic [0:0] d1, q1;
    logic       so1, ch1;

    d_reg_universal #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clk_in(clk), .reset_in(rst8), .en_in(en8), .mode_in(mode8),
        .d_in(d8), .si_in(si8), .q_out(q8), .so_out(so8), .changed_out(ch8)
    );

    d_reg_universal #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
        .clk_in(clk), .reset_in(rst1), .en_in(en1), .mode_in(mode1),
        .d_in(d1), .si_in(si1), .q_out(q1), .so_out(so1), .changed_out(ch1)
    );

    int tests  = 0;
    int failed = 0;

    vec_t t8[$];
    vec_t t1[$];

    function automatic vec_t mk(logic rst, logic en, logic [2:0] mode,
                                logic [7:0] d, logic si,
                                logic [7:0] q, logic so, logic ch);
        vec_t v;
        v.rst = rst; v.en = en; v.mode = mode; v.d = d; v.si = si;
        v.q = q; v.so = so; v.ch = ch;
        return v;
    endfunction

    task automatic check(string name, int idx,
                         logic [7:0] aq, logic aso, logic ach,
                         logic [7:0] eq, logic eso, logic ech);
        tests++;
        if (aq !== eq || aso !== eso || ach !== ech) begin
            failed++;
            $display("FAIL %s #%0d: got q=%h so=%b ch=%b, expected q=%h so=%b ch=%b",
                     name, idx, aq, aso, ach, eq, eso, ech);
        end
    endtask

    // Behavioural reference: arithmetic on integers, word width as a value.
    function automatic void model(int w, logic [7:0] rv, logic rst, logic en,
                                  logic [2:0] mode, logic [7:0] d, logic si,
                                  inout logic [7:0] q, inout logic so,
                                  output logic ch);
        int unsigned mask, cur, nxt, top;
        mask = (1 << w) - 1;
        cur  = int'(q) & mask;
        top  = (cur >> (w - 1)) & 1;
        nxt  = cur;
        if (rst) begin
            q = rv; so = 1'b0; ch = 1'b0;
            return;
        end
        if (en) begin
            case (mode)
                3'd1: nxt = int'(d) & mask;
                3'd2: begin nxt = ((cur * 2) + si) & mask;                   so = top[0]; end
                3'd3: begin nxt = (cur / 2) + (int'(si) << (w - 1));         so = cur[0]; end
                3'd4: begin nxt = ((cur * 2) + top) & mask;                  so = top[0]; end
                3'd5: begin nxt = (cur / 2) + ((cur & 1) << (w - 1));        so = cur[0]; end
                3'd6: nxt = mask;
                3'd7: nxt = 0;
                default: nxt = cur;
            endcase
        end
        ch = (nxt != cur);
        q  = nxt[7:0];
    endfunction

    initial begin
        logic [7:0] m8q, m1q;
        logic       m8so, m8ch, m1so, m1ch;

        // ---------------- WIDTH=8 directed table ----------------
        t8.push_back(mk(1,1,MODE_SET ,8'h00,0, 8'hA5,0,0));
        t8.push_back(mk(1,1,MODE_SET ,8'h00,0, 8'hA5,0,0));
        t8.push_back(mk(0,1,MODE_LOAD,8'h3C,0, 8'h3C,0,1));
        t8.push_back(mk(0,0,MODE_CLR ,8'h00,0, 8'h3C,0,0));
        t8.push_back(mk(0,0,MODE_CLR ,8'h00,0, 8'h3C,0,0));
        t8.push_back(mk(0,0,MODE_CLR ,8'h00,0, 8'h3C,0,0));
        t8.push_back(mk(0,1,MODE_LOAD,8'h81,0, 8'h81,0,1));
        t8.push_back(mk(0,1,MODE_SHL ,8'h00,0, 8'h02,1,1));
        t8.push_back(mk(0,1,MODE_SHR ,8'h00,1, 8'h81,0,1));
        t8.push_back(mk(0,1,MODE_LOAD,8'h01,0, 8'h01,0,1));
        for (int i = 0; i < 8; i++) begin
            logic [7:0] r;
            r = 8'h80 >> i;
            t8.push_back(mk(0,1,MODE_ROTR,8'h00,0, (i == 7) ? 8'h01 : r, (i == 0), 1));
        end
        t8.push_back(mk(0,1,MODE_LOAD,8'hFF,0, 8'hFF,0,1));
        t8.push_back(mk(0,1,MODE_SHL ,8'h00,0, 8'hFE,1,1));
        t8.push_back(mk(0,1,MODE_SHL ,8'h00,0, 8'hFC,1,1));
        t8.push_back(mk(0,1,MODE_SHL ,8'h00,0, 8'hF8,1,1));
        t8.push_back(mk(1,1,MODE_SHL ,8'h00,0, 8'hA5,0,0));
        t8.push_back(mk(0,1,MODE_SHL ,8'h00,0, 8'h4A,1,1));
        t8.push_back(mk(0,1,MODE_LOAD,8'h77,0, 8'h77,1,1));
        t8.push_back(mk(0,1,MODE_LOAD,8'h77,0, 8'h77,1,0));
        t8.push_back(mk(1,1,MODE_SET ,8'h00,0, 8'hA5,0,0));
        t8.push_back(mk(0,1,MODE_SET ,8'h00,0, 8'hFF,0,1));
        t8.push_back(mk(0,1,MODE_SET ,8'h00,0, 8'hFF,0,0));
        t8.push_back(mk(0,1,MODE_CLR ,8'h00,0, 8'h00,0,1));
        t8.push_back(mk(0,1,MODE_HOLD,8'h5A,1, 8'h00,0,0));
        t8.push_back(mk(0,1,MODE_ROTL,8'h00,1, 8'h00,0,0));
        t8.push_back(mk(0,0,MODE_SHL ,8'h00,1, 8'h00,0,0));

        // ---------------- WIDTH=1 directed table ----------------
        t1.push_back(mk(1,1,MODE_SET ,8'h00,0, 8'h00,0,0));
        t1.push_back(mk(0,1,MODE_SHL ,8'h00,1, 8'h01,0,1));
        t1.push_back(mk(0,1,MODE_SHL ,8'h00,0, 8'h00,1,1));
        t1.push_back(mk(0,1,MODE_SHL ,8'h00,1, 8'h01,0,1));
        t1.push_back(mk(0,1,MODE_ROTL,8'h00,0, 8'h01,1,0));
        t1.push_back(mk(0,1,MODE_ROTR,8'h00,0, 8'h01,1,0));
        t1.push_back(mk(0,1,MODE_SHR ,8'h00,0, 8'h00,1,1));
        t1.push_back(mk(0,1,MODE_SET ,8'h00,0, 8'h01,1,1));

        rst1 = 1; en1 = 0; mode1 = 3'd0; d1 = 1'b0; si1 = 0;
        rst8 = 1; en8 = 0; mode8 = 3'd0; d8 = 8'h00; si8 = 0;
        @(posedge clk); #1;

        foreach (t8[i]) begin
            rst8 = t8[i].rst; en8 = t8[i].en; mode8 = t8[i].mode;
            d8 = t8[i].d; si8 = t8[i].si;
            @(posedge clk); #1;
            check("w8_table", i, q8, so8, ch8, t8[i].q, t8[i].so, t8[i].ch);
        end

        foreach (t1[i]) begin
            rst1 = t1[i].rst; en1 = t1[i].en; mode1 = t1[i].mode;
            d1 = t1[i].d[0]; si1 = t1[i].si;
            @(posedge clk); #1;
            check("w1_table", i, {7'd0, q1}, so1, ch1, t1[i].q, t1[i].so, t1[i].ch);
        end

        // ---------------- randomized, both widths in parallel ----------------
        rst8 = 1; rst1 = 1;
        @(posedge clk); #1;
        m8q = 8'hA5; m8so = 0; m8ch = 0;
        m1q = 8'h00; m1so = 0; m1ch = 0;
        check("w8_rand_reset", 0, q8, so8, ch8, m8q, m8so, m8ch);
        check("w1_rand_reset", 0, {7'd0, q1}, so1, ch1, m1q, m1so, m1ch);

        for (int i = 0; i < 400; i++) begin
            rst8  = ($urandom_range(0, 19) == 0);
            en8   = ($urandom_range(0, 3) != 0);
            mode8 = 3'($urandom_range(0, 7));
            d8    = 8'($urandom);
            si8   = 1'($urandom);
            rst1  = ($urandom_range(0, 19) == 0);
            en1   = ($urandom_range(0, 3) != 0);
            mode1 = 3'($urandom_range(0, 7));
            d1    = 1'($urandom);
            si1   = 1'($urandom);
            model(8, 8'hA5, rst8, en8, mode8, d8, si8, m8q, m8so, m8ch);
            model(1, 8'h00, rst1, en1, mode1, {7'd0, d1}, si1, m1q, m1so, m1ch);
            @(posedge clk); #1;
            check("w8_rand", i, q8, so8, ch8, m8q, m8so, m8ch);
            check("w1_rand", i, {7'd0, q1}, so1, ch1, m1q, m1so, m1ch);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/d_reg_universal.md
# d_reg_universal

Parametrised, clocked universal data register: the clocked successor to the team's enable-gated D latch with reset. It holds a WIDTH-bit word and, on each enabled rising clock edge, executes one of eight modes: hold, parallel load, shift left/right, rotate left/right, set-all, clear. It also reports which bit was shifted out and flags any change of the stored word. It sits as a general-purpose storage/serialiser element in datapath and I/O blocks.

## Interface
- WIDTH, 8, stored word width in bits (≥1)
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q_out on reset
- clk_in  input  1  single clock, all state updates on rising edge
- reset_in  input  1  synchronous, active-high reset; sampled on clk_in rising edge only
- en_in  input  1  update enable; 0 = hold regardless of mode_in
- mode_in  input  3  operation select (codes below)
- d_in  input  WIDTH  parallel load data
- si_in  input  1  serial input bit for shifts
- q_out  output  WIDTH  stored word (registered)
- so_out  output  1  bit expelled by the most recent shift (registered)
- changed_out  output  1  one-cycle pulse: q_out changed on the previous edge

## Operation
- Mode codes: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROTL, 5 ROTR, 6 SET, 7 CLR.
- LOAD: q ← d_in.
- SHL: q ← {q[WIDTH-2:0], si_in}; so ← q[WIDTH-1].
- SHR: q ← {si_in, q[WIDTH-1:1]}; so ← q[0].
- ROTL: q ← {q[WIDTH-2:0], q[WIDTH-1]}; so ← q[WIDTH-1].
- ROTR: q ← {q[0], q[WIDTH-1:1]}; so ← q[0].
- SET: q ← all ones. CLR: q ← all zeros. HOLD: q unchanged.
- so_out updates only on enabled SHL/SHR/ROTL/ROTR; every other mode and en_in=0 leaves it unchanged.
- changed_out ← (q_next != q) on every edge, enabled or not; it is 0 whenever q is held.
- WIDTH=1: SHL/SHR reduce to q ← si_in, so ← old q; ROTL/ROTR leave q unchanged (changed_out=0), so ← q.
- Priority: reset_in > en_in > mode_in.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Latency: one clock from sampled en_in/mode_in/d_in/si_in to q_out/so_out; changed_out is asserted in the same cycle as the new q_out value.
- Reset: on an edge with reset_in=1: q_out ← RESET_VALUE, so_out ← 0, changed_out ← 0, independent of en_in/mode_in. Reset asserted mid-shift sequence aborts it; the first enabled edge after release operates on RESET_VALUE.
- Reset between edges has no effect until the next rising edge (synchronous; the latch's level-sensitivity is not retained).
- Repeated identical LOAD: changed_out=0 after the first edge.
- Reset released on the same edge as en_in=1: reset still wins that edge; the mode executes on the following edge.

## Structure
- Shared package/header d_reg_defs: the eight mode-code constants and the mode field width (3); used by RTL and bench.
- One sub-module, d_reg_next_mux: purely combinational next-state function (q, mode, en, d, si) → (q_next, so_next, so_update); d_reg_universal holds only the three registers and the change compare.

## Test plan
- Reset: WIDTH=8, RESET_VALUE=8'hA5, reset_in=1 for 2 edges with en_in=1, mode=SET → q_out=8'hA5, so_out=0, changed_out=0.
- Load/hold: LOAD d_in=8'h3C, then en_in=0 with mode=CLR for 3 edges → q_out=8'h3C throughout, changed_out 1 then 0,0,0.
- Shift: from 8'h81, SHL si=0 → q=8'h02, so=1; SHR si=1 → q=8'h81, so=0.
- Rotate: from 8'h01, 8× ROTR → returns to 8'h01; so_out sequence 1,0,0,0,0,0,0,0; changed_out=1 every edge.
- Mid-operation reset: shifting 8'hFF with SHL si=0, assert reset_in after 3 edges (q=8'hF8) → next edge q=RESET_VALUE, so=0; release → SHL continues from RESET_VALUE.
- WIDTH=1 instance: SHL si alternating 1,0,1 → q=1,0,1, so=old q; ROTL → q unchanged, changed_out=0.
